// File: rtl/quadtest_cpu_oci_trace_capture.sv
// Trace capture FIFO for the OCI debug path.
// Captures {dct_count, dct_buffer} words while enabled, presents them
// first-word-fall-through to a consumer, and drains to a sticky "ended"
// state when a test-ending request arrives.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   dct_buffer        trace data word (ENTRY_W)
//   dct_count         valid-item count qualifying dct_buffer (COUNT_W)
//   dct_valid         dct_buffer/dct_count valid this cycle
//   capture_en        level enable for capture
//   test_ending       request to stop capture and drain
//   rd_ready          consumer accepts rd_data
//   rd_data           head entry {count, buffer}
//   rd_valid          FIFO not empty
//   fill_level        occupancy, 0..DEPTH
//   overflow_cnt      dropped/overwritten entries, saturating
//   test_has_ended    drain complete, sticky until reset
module quadtest_cpu_oci_trace_capture #(
  parameter int unsigned ENTRY_W   = 30,
  parameter int unsigned COUNT_W   = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ENTRY_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       dct_valid,
  input  logic                       capture_en,
  input  logic                       test_ending,
  input  logic                       rd_ready,
  output logic [COUNT_W+ENTRY_W-1:0] rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [15:0]                overflow_cnt,
  output logic                       test_has_ended
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FILL_W = AW + 1;
  localparam int unsigned DATA_W = COUNT_W + ENTRY_W;
  localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

  // One-hot so the ended flag is a single flop bit.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_CAPTURE = 4'b0010,
    ST_DRAIN   = 4'b0100,
    ST_ENDED   = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic              capture_active;
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [15:0]       ovf_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic full, push_req, pop, do_write, adv_rd, ovf_evt;

  // FIFO control: push/pop decisions and next occupancy.
  always_comb begin
    full     = (fill_q == FULL_LEVEL);
    push_req = capture_active & dct_valid & (dct_count != '0);
    pop      = (fill_q != '0) & rd_ready;
    do_write = 1'b0;
    adv_rd   = pop;
    ovf_evt  = 1'b0;
    fill_d   = fill_q;
    if (push_req && !pop && full) begin
      ovf_evt = 1'b1;
      // Overwrite: tail and head coincide when full, so writing and
      // advancing the head together discards the oldest entry.
      if (WRAP_MODE != 0) begin
        do_write = 1'b1;
        adv_rd   = 1'b1;
      end
    end else if (push_req) begin
      do_write = 1'b1;
      if (!pop) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end else if (pop) begin
      fill_d = fill_q - FILL_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN ends on the edge the FIFO goes (or is) empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (test_ending) begin
          state_d = ST_DRAIN;
        end else if (capture_en) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (test_ending) begin
          state_d = ST_DRAIN;
        end else if (!capture_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (fill_d == '0) begin
          state_d = ST_ENDED;
        end
      end
      ST_ENDED: begin
        state_d = ST_ENDED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State decode.
  always_comb begin
    capture_active = 1'b0;
    test_has_ended = 1'b0;
    if (state_q == ST_CAPTURE) begin
      capture_active = 1'b1;
    end
    if (state_q == ST_ENDED) begin
      test_has_ended = 1'b1;
    end
  end

  // Pointers, occupancy and saturating overflow counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (adv_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fill_q <= fill_d;
      if (ovf_evt && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  // Storage array; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= {dct_count, dct_buffer};
    end
  end

  assign rd_data      = mem[rd_ptr_q];
  assign rd_valid     = (fill_q != '0);
  assign fill_level   = fill_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_quadtest_cpu_oci_trace_capture.sv
// Testbench: drop-mode and overwrite-mode instances driven in parallel and
// compared against a queue-based reference model.
module tb_quadtest_cpu_oci_trace_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, capture_en, test_ending, rd_ready;

  logic [33:0] data0, data1;
  logic        valid0, valid1, ended0, ended1;
  logic [4:0]  fill0, fill1;
  logic [15:0] ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 capture, 2 drain, 3 ended.
  logic [33:0] q0[$];
  logic [33:0] q1[$];
  int          ms[2];
  int unsigned movf[2];

  always #5 clk = ~clk;

  quadtest_cpu_oci_trace_capture #(.ENTRY_W(30), .COUNT_W(4), .DEPTH(DEPTH), .WRAP_MODE(0)) u_drop (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .capture_en(capture_en), .test_ending(test_ending),
    .rd_ready(rd_ready), .rd_data(data0), .rd_valid(valid0), .fill_level(fill0),
    .overflow_cnt(ovf0), .test_has_ended(ended0));

  quadtest_cpu_oci_trace_capture #(.ENTRY_W(30), .COUNT_W(4), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .capture_en(capture_en), .test_ending(test_ending),
    .rd_ready(rd_ready), .rd_data(data1), .rd_valid(valid1), .fill_level(fill1),
    .overflow_cnt(ovf1), .test_has_ended(ended1));

  logic [56:0] obs0, obs1;
  assign obs0 = {ended0, ovf0, fill0, valid0, valid0 ? data0 : 34'd0};
  assign obs1 = {ended1, ovf1, fill1, valid1, valid1 ? data1 : 34'd0};

  function automatic logic [33:0] ent(input int i);
    return {4'((i % 15) + 1), 30'(i)};
  endfunction

  function automatic logic [56:0] exp_vec(input int k);
    logic [33:0] head;
    int n;
    head = '0;
    if (k == 0) begin
      n = q0.size();
      if (n != 0) head = q0[0];
    end else begin
      n = q1.size();
      if (n != 0) head = q1[0];
    end
    return {ms[k] == 3, 16'(movf[k]), 5'(n), n != 0, head};
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ms[0] = 0; ms[1] = 0;
    movf[0] = 0; movf[1] = 0;
  endtask

  // One clock of the behavioural rules, evaluated on the inputs in force at the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [33:0] q[$];
      bit pop, push;
      if (k == 0) q = q0; else q = q1;
      pop  = (q.size() != 0) && rd_ready;
      push = (ms[k] == 1) && dct_valid && (dct_count != 4'd0);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          q.push_back({dct_count, dct_buffer});
        end else begin
          if (movf[k] < 65535) movf[k]++;
          if (k == 1) begin
            void'(q.pop_front());
            q.push_back({dct_count, dct_buffer});
          end
        end
      end
      case (ms[k])
        0: if (test_ending) ms[k] = 2; else if (capture_en) ms[k] = 1;
        1: if (test_ending) ms[k] = 2; else if (!capture_en) ms[k] = 0;
        2: if (q.size() == 0) ms[k] = 3;
        default: ;
      endcase
      if (k == 0) q0 = q; else q1 = q;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    capture_en = 1'b0; test_ending = 1'b0; dct_valid = 1'b0;
    dct_count = '0; dct_buffer = '0; rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    idle_inputs();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({fill0, valid0, ovf0, ended0, fill1, valid1, ovf1, ended1} !== '0) begin
      errors++;
      $display("FAIL reset_async got fill=%0d/%0d valid=%b/%b ovf=%0d/%0d ended=%b/%b exp all 0",
               fill0, fill1, valid0, valid1, ovf0, ovf1, ended0, ended1);
    end
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      errors++;
      $display("FAIL reset_idle got=%h/%h exp=%h/%h", obs0, obs1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_basic();
    do_reset();
    capture_en = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      dct_valid = 1'b1; dct_count = 4'(i); dct_buffer = 30'(i);
      step();
    end
    dct_valid = 1'b0;
    checks++;
    if (fill0 !== 5'd3 || fill1 !== 5'd3 || data0 !== {4'd1, 30'h1} || data1 !== {4'd1, 30'h1}) begin
      errors++;
      $display("FAIL basic_fill got fill=%0d/%0d head=%h/%h exp 3 head=%h", fill0, fill1, data0, data1, {4'd1, 30'h1});
    end
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (!valid0 || data0 !== {4'(i), 30'(i)} || !valid1 || data1 !== {4'(i), 30'(i)}) begin
        errors++;
        $display("FAIL basic_pop%0d got=%h/%h valid=%b/%b exp=%h", i, data0, data1, valid0, valid1, {4'(i), 30'(i)});
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      errors++;
      $display("FAIL basic_empty got valid=%b/%b obs=%h/%h exp=%h/%h", valid0, valid1, obs0, obs1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    capture_en = 1'b1;
    step();
    for (int i = 1; i <= 20; i++) begin
      dct_valid = 1'b1; {dct_count, dct_buffer} = ent(i);
      step();
    end
    dct_valid = 1'b0;
    checks++;
    if (fill0 !== 5'd16 || ovf0 !== 16'd4 || data0 !== ent(1)) begin
      errors++;
      $display("FAIL ovf_drop got fill=%0d ovf=%0d head=%h exp 16 4 %h", fill0, ovf0, data0, ent(1));
    end
    checks++;
    if (fill1 !== 5'd16 || ovf1 !== 16'd4 || data1 !== ent(5)) begin
      errors++;
      $display("FAIL ovf_wrap got fill=%0d ovf=%0d head=%h exp 16 4 %h", fill1, ovf1, data1, ent(5));
    end
  endtask

  // Runs on the full FIFOs left by test_overflow.
  task automatic test_full_push_pop();
    dct_valid = 1'b1; {dct_count, dct_buffer} = ent(21); rd_ready = 1'b1;
    step();
    dct_valid = 1'b0; rd_ready = 1'b0;
    checks++;
    if (fill0 !== 5'd16 || fill1 !== 5'd16 || ovf0 !== 16'd4 || ovf1 !== 16'd4 ||
        data0 !== ent(2) || data1 !== ent(6)) begin
      errors++;
      $display("FAIL full_pushpop got fill=%0d/%0d ovf=%0d/%0d head=%h/%h exp 16 4 %h/%h",
               fill0, fill1, ovf0, ovf1, data0, data1, ent(2), ent(6));
    end
    rd_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      logic [33:0] e0, e1;
      e0 = (j < 15) ? ent(2 + j) : ent(21);
      e1 = (j < 15) ? ent(6 + j) : ent(21);
      checks++;
      if (data0 !== e0 || data1 !== e1 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL full_order%0d got=%h/%h exp=%h/%h", j, data0, data1, e0, e1);
      end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    capture_en = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      dct_valid = 1'b1; {dct_count, dct_buffer} = ent(i);
      step();
    end
    test_ending = 1'b1; {dct_count, dct_buffer} = ent(5);
    step();
    test_ending = 1'b0; {dct_count, dct_buffer} = ent(6);
    step();
    step();
    checks++;
    if (fill0 !== 5'd5 || fill1 !== 5'd5 || ended0 || ended1) begin
      errors++;
      $display("FAIL drain_nopush got fill=%0d/%0d ended=%b/%b exp 5 0", fill0, fill1, ended0, ended1);
    end
    rd_ready = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      checks++;
      if (ended0 !== 1'b0 || ended1 !== 1'b0 || data0 !== ent(p) || data1 !== ent(p)) begin
        errors++;
        $display("FAIL drain_pop%0d got ended=%b/%b head=%h/%h exp 0 %h", p, ended0, ended1, data0, data1, ent(p));
      end
      step();
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ended0 !== 1'b1 || ended1 !== 1'b1 || fill0 !== 5'd0 || fill1 !== 5'd0 ||
          obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL drain_ended%0d got ended=%b/%b fill=%0d/%0d exp 1 0", c, ended0, ended1, fill0, fill1);
      end
      test_ending = c[0]; capture_en = ~c[1];
      step();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    capture_en = 1'b1;
    step();
    for (int i = 1; i <= 18; i++) begin
      dct_valid = 1'b1; {dct_count, dct_buffer} = ent(i);
      step();
    end
    dct_valid = 1'b0; test_ending = 1'b1;
    step();
    test_ending = 1'b0; rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    checks++;
    if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1) || ovf0 !== 16'd2) begin
      errors++;
      $display("FAIL async_pre got=%h/%h exp=%h/%h", obs0, obs1, exp_vec(0), exp_vec(1));
    end
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fill0, valid0, ovf0, ended0, fill1, valid1, ovf1, ended1} !== '0) begin
      errors++;
      $display("FAIL async_mid got fill=%0d/%0d valid=%b/%b ovf=%0d/%0d ended=%b/%b exp all 0",
               fill0, fill1, valid0, valid1, ovf0, ovf1, ended0, ended1);
    end
    model_clear();
    @(negedge clk);
    capture_en = 1'b1; dct_valid = 1'b1; {dct_count, dct_buffer} = ent(7); rd_ready = 1'b1;
    reset_n = 1'b1;
    step();
    checks++;
    if (fill0 !== 5'd0 || fill1 !== 5'd0 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      errors++;
      $display("FAIL async_release got=%h/%h exp=%h/%h", obs0, obs1, exp_vec(0), exp_vec(1));
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int budget;
      do_reset();
      capture_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 15) == 0) capture_en = ~capture_en;
        dct_valid  = ($urandom_range(0, 3) != 0);
        dct_count  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
        dct_buffer = 30'($urandom);
        rd_ready   = ($urandom_range(0, 9) < (r * 3 + 1));
        step();
        checks++;
        if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
          errors++;
          $display("FAIL rand r=%0d c=%0d got=%h/%h exp=%h/%h", r, c, obs0, obs1, exp_vec(0), exp_vec(1));
        end
      end
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      budget = 0;
      while (!(ms[0] == 3 && ms[1] == 3 && ended0 && ended1) && budget < 300) begin
        rd_ready = $urandom_range(0, 1);
        dct_valid = 1'b1; dct_count = 4'd1;
        step();
        budget++;
        checks++;
        if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
          errors++;
          $display("FAIL rand_drain r=%0d got=%h/%h exp=%h/%h", r, obs0, obs1, exp_vec(0), exp_vec(1));
        end
      end
      checks++;
      if (ended0 !== 1'b1 || ended1 !== 1'b1) begin
        errors++;
        $display("FAIL rand_timeout r=%0d got ended=%b/%b exp 1", r, ended0, ended1);
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadtest_cpu_oci_trace_capture.md
QUADTEST_CPU_OCI_TRACE_CAPTURE -- requirements
Module: quadtest_cpu_oci_trace_capture

Interface
REQ-001 Parameter ENTRY_W, default 30, width of the dct_buffer trace word.
REQ-002 Parameter COUNT_W, default 4, width of the dct_count field.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-004 Parameter WRAP_MODE, default 0: 0 = drop new entry when full, 1 = overwrite oldest entry.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 dct_buffer  in  ENTRY_W  trace data word.
REQ-008 dct_count  in  COUNT_W  valid-item count qualifying dct_buffer.
REQ-009 dct_valid  in  1  dct_buffer/dct_count valid this cycle.
REQ-010 capture_en  in  1  level enable for capture.
REQ-011 test_ending  in  1  request to stop capture and drain.
REQ-012 rd_ready  in  1  consumer accepts rd_data.
REQ-013 rd_data  out  COUNT_W+ENTRY_W  head entry, {count, buffer}.
REQ-014 rd_valid  out  1  FIFO not empty.
REQ-015 fill_level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow_cnt  out  16  dropped/overwritten entries, saturating.
REQ-017 test_has_ended  out  1  drain complete, sticky.

Function
REQ-018 FSM states IDLE, CAPTURE, DRAIN, ENDED; encoding free.
REQ-019 IDLE->CAPTURE when capture_en=1; CAPTURE->IDLE when capture_en=0; FIFO contents retained across both.
REQ-020 test_ending=1 in IDLE or CAPTURE -> DRAIN next cycle; takes priority over capture_en.
REQ-021 DRAIN->ENDED on the cycle the FIFO becomes or is empty; ENDED held until reset; test_ending ignored in DRAIN/ENDED.
REQ-022 Push condition: state CAPTURE, dct_valid=1, dct_count!=0; dct_count=0 entries discarded silently, not counted.
REQ-023 Pushed entry = {dct_count, dct_buffer}; visible on rd_data one cycle after push when FIFO was empty.
REQ-024 rd_data is first-word-fall-through from head; rd_valid = (fill_level!=0), registered-state derived.
REQ-025 Pop when rd_valid=1 and rd_ready=1; popping allowed in every state.
REQ-026 Push and pop same cycle: both occur, fill_level unchanged, no overflow, including when full.
REQ-027 Push when full, no pop, WRAP_MODE=0: entry dropped, FIFO unchanged, overflow_cnt +1.
REQ-028 Push when full, no pop, WRAP_MODE=1: oldest entry discarded, new entry written, fill_level stays DEPTH, overflow_cnt +1; rd_data may change while rd_valid=1.
REQ-029 overflow_cnt saturates at 0xFFFF, never wraps.
REQ-030 Pointers wrap modulo DEPTH; fill_level never exceeds DEPTH nor underflows.
REQ-031 test_has_ended = 1 iff state is ENDED.

Reset
REQ-032 reset_n=0 asynchronously forces: state IDLE, pointers 0, fill_level 0, rd_valid 0, overflow_cnt 0, test_has_ended 0; rd_data don't-care while rd_valid=0.
REQ-033 Reset mid-capture or mid-drain discards all entries; no push/pop on the release edge beyond normal REQ-022/025 rules.

Verification
REQ-034 capture_en=1, push 3 entries count=1..3 buffer=0x1,0x2,0x3, rd_ready=0 -> fill_level=3, rd_data={1,0x1}; then rd_ready=1 3 cycles -> data in order, rd_valid=0.
REQ-035 WRAP_MODE=0, DEPTH=16, push 20 entries, no pop -> fill_level=16, overflow_cnt=4, head = entry 1.
REQ-036 WRAP_MODE=1, same stimulus -> fill_level=16, overflow_cnt=4, head = entry 5, tail = entry 20.
REQ-037 Full FIFO, push + pop same cycle -> fill_level=16, overflow_cnt unchanged.
REQ-038 5 entries queued, pulse test_ending, keep dct_valid=1 -> no further pushes; after 5 pops test_has_ended=1 next cycle, stays 1 until reset_n=0.
REQ-039 Assert reset_n=0 asynchronously mid-drain -> all outputs at REQ-032 values before next clk edge.
